bist_next_sequencer: RTL and testbench
======================================

BIST_NEXT_SEQUENCER -- requirements
Module: bist_next_sequencer

Interface
REQ-001 Parameter STEP_W, default 8, width of the step count and step index.
REQ-002 Parameter TO_W, default 16, width of the per-phase timeout counter.
REQ-003 bist_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to run a sequence.
REQ-006 num_steps  input  STEP_W  number of bist_next handshakes to issue; sampled on an accepted start.
REQ-007 timeout_cycles  input  TO_W  per-phase timeout limit; sampled on an accepted start; 0 disables the timeout.
REQ-008 abort  input  1  cancels a running sequence.
REQ-009 bist_next  output  1  registered request to the downstream BIST stage.
REQ-010 bist_next_ack  input  1  acknowledge from the downstream BIST stage.
REQ-011 busy  output  1  high in states REQ and RELEASE.
REQ-012 done  output  1  one-cycle pulse on successful completion.
REQ-013 error  output  1  sticky timeout flag.
REQ-014 step_cnt  output  STEP_W  number of completed handshakes in the current or last sequence.
REQ-015 err_step  output  STEP_W  value of step_cnt at the timeout.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, REQ, RELEASE.
REQ-017 Handshake: 4-phase. bist_next rises; ack rises; bist_next falls; ack falls. One step completes at the edge that samples ack low in RELEASE.
REQ-018 IDLE, start=1, ack=0, num_steps!=0: latch num_steps and timeout_cycles; clear step_cnt and error; go to REQ. bist_next SHALL be high in the next cycle (1-cycle latency).
REQ-019 IDLE, start=1, ack=0, num_steps==0: clear step_cnt and error; pulse done in the next cycle; stay in IDLE.
REQ-020 In IDLE, start with ack=1 SHALL be ignored (no state, counter or flag change).
REQ-021 In REQ, bist_next=1; on the edge sampling ack=1, go to RELEASE with bist_next=0 in the following cycle.
REQ-022 In RELEASE, bist_next=0; on the edge sampling ack=0, increment step_cnt.
REQ-023 On that same edge, if the incremented step_cnt equals the latched num_steps: go to IDLE and pulse done for exactly 1 cycle. Otherwise go to REQ.
REQ-024 Timeout counter: cleared on every entry to REQ or RELEASE; increments each cycle spent waiting in those states.
REQ-025 When the timeout counter equals a nonzero latched timeout_cycles: go to IDLE, drive bist_next=0, set error=1, capture err_step=step_cnt. No done pulse.
REQ-026 error and err_step SHALL hold until reset or the next accepted start.
REQ-027 abort=1 in REQ or RELEASE: go to IDLE next cycle with bist_next=0. No done, no error change; step_cnt holds.
REQ-028 Simultaneous-event priority: abort over timeout over handshake progress. In IDLE, abort together with start SHALL cause start to be ignored.
REQ-029 start while busy SHALL be ignored.
REQ-030 ack changes in IDLE SHALL have no effect.
REQ-031 step_cnt never wraps: num_steps max is 2^STEP_W-1 and the equality check terminates the sequence first.

Reset
REQ-032 reset=1 at any edge, including mid-sequence, SHALL force: IDLE, bist_next=0, busy=0, done=0, error=0, step_cnt=0, err_step=0, timeout counter=0.
REQ-033 reset SHALL take priority over all other inputs.

Verification
REQ-034 num_steps=3, timeout=0, ack echoes bist_next with 2-cycle delay -> three bist_next pulses, step_cnt=3, single done pulse, error=0.
REQ-035 num_steps=0 start -> done pulse next cycle, bist_next never rises, busy stays 0.
REQ-036 num_steps=4, timeout_cycles=5, ack held 0 after step 2's request -> IDLE after 5 waiting cycles, error=1, err_step=2, bist_next=0, no done.
REQ-037 abort during RELEASE of step 1 -> IDLE next cycle, step_cnt=1, done=0, error=0. A following start runs the sequence normally.
REQ-038 reset asserted in REQ with ack=1 -> all outputs zero next cycle; start while ack=1 is ignored; start after ack falls is accepted.
REQ-039 abort and timeout expiry on the same edge -> abort behaviour, error=0.

Source files
------------

// File: rtl/bist_next_sequencer.sv
// bist_next_sequencer: issues a counted series of 4-phase bist_next
// handshakes to a downstream BIST stage, with per-phase timeout and abort.
//
// Ports:
//   bist_clk        in   clock, all state changes on its rising edge
//   reset           in   synchronous active-high reset
//   start           in   one-cycle request to run a sequence
//   num_steps       in   handshake count, sampled on an accepted start
//   timeout_cycles  in   per-phase wait limit (0 = no limit), sampled on start
//   abort           in   cancels a running sequence
//   bist_next       out  registered request to the downstream stage
//   bist_next_ack   in   acknowledge from the downstream stage
//   busy            out  sequence in progress (REQ or RELEASE)
//   done            out  one-cycle pulse on successful completion
//   error           out  sticky timeout flag
//   step_cnt        out  completed handshakes in current/last sequence
//   err_step        out  step_cnt captured at the timeout
module bist_next_sequencer #(
    parameter int STEP_W = 8,
    parameter int TO_W   = 16
) (
    input  logic              bist_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [TO_W-1:0]   timeout_cycles,
    input  logic              abort,
    output logic              bist_next,
    input  logic              bist_next_ack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [STEP_W-1:0] step_cnt,
    output logic [STEP_W-1:0] err_step
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic              bn_q,     bn_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;
    logic [STEP_W-1:0] step_q,   step_d;
    logic [STEP_W-1:0] estep_q,  estep_d;
    logic [STEP_W-1:0] nsteps_q, nsteps_d;
    logic [TO_W-1:0]   tlim_q,   tlim_d;
    logic [TO_W-1:0]   tmo_q,    tmo_d;

    logic [TO_W-1:0]   tmo_inc;
    logic [TO_W-1:0]   tmo_wait;
    logic              tmo_hit;
    logic [STEP_W-1:0] step_inc;
    logic              start_ok;

    assign tmo_inc  = tmo_q + TO_W'(1);
    // With the limit disabled the counter is frozen so it never wraps.
    assign tmo_wait = (tlim_q != '0) ? tmo_inc : tmo_q;
    // Fires on the edge that completes the limit-th waiting cycle.
    assign tmo_hit  = (tlim_q != '0) && (tmo_inc == tlim_q);
    assign step_inc = step_q + STEP_W'(1);

    // Start is only honoured with the downstream side idle and no abort.
    assign start_ok = start && !bist_next_ack && !abort;

    always_comb begin
        state_d  = state_q;
        bn_d     = bn_q;
        done_d   = 1'b0;
        err_d    = err_q;
        step_d   = step_q;
        estep_d  = estep_q;
        nsteps_d = nsteps_q;
        tlim_d   = tlim_q;
        tmo_d    = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                bn_d  = 1'b0;
                tmo_d = '0;
                if (start_ok) begin
                    step_d  = '0;
                    err_d   = 1'b0;
                    estep_d = '0;
                    if (num_steps != '0) begin
                        nsteps_d = num_steps;
                        tlim_d   = timeout_cycles;
                        state_d  = S_REQ;
                        bn_d     = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_REQ: begin
                if (abort) begin
                    state_d = S_IDLE;
                    bn_d    = 1'b0;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    bn_d    = 1'b0;
                    tmo_d   = '0;
                    err_d   = 1'b1;
                    estep_d = step_q;
                end else if (bist_next_ack) begin
                    state_d = S_REL;
                    bn_d    = 1'b0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_wait;
                end
            end

            S_REL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    bn_d    = 1'b0;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    bn_d    = 1'b0;
                    tmo_d   = '0;
                    err_d   = 1'b1;
                    estep_d = step_q;
                end else if (!bist_next_ack) begin
                    step_d = step_inc;
                    tmo_d  = '0;
                    // Equality ends the run before step_cnt can wrap.
                    if (step_inc == nsteps_q) begin
                        state_d = S_IDLE;
                        bn_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        bn_d    = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_wait;
                end
            end

            default: begin
                state_d = S_IDLE;
                bn_d    = 1'b0;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge bist_clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bn_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            step_q   <= '0;
            estep_q  <= '0;
            nsteps_q <= '0;
            tlim_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            bn_q     <= bn_d;
            done_q   <= done_d;
            err_q    <= err_d;
            step_q   <= step_d;
            estep_q  <= estep_d;
            nsteps_q <= nsteps_d;
            tlim_q   <= tlim_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bist_next = bn_q;
    assign busy      = (state_q == S_REQ) || (state_q == S_REL);
    assign done      = done_q;
    assign error     = err_q;
    assign step_cnt  = step_q;
    assign err_step  = estep_q;

endmodule

// File: tb/tb_bist_next_sequencer.sv
// Testbench for bist_next_sequencer: scoreboard of per-sequence outcomes
// against an ack model echoing bist_next with a 2-cycle delay.
module tb_bist_next_sequencer;

    logic       bist_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_steps = '0;
    logic [15:0] timeout_cycles = '0;
    logic       abort = 1'b0;
    logic       bist_next;
    logic       bist_next_ack;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] step_cnt;
    logic [7:0] err_step;

    always #5 bist_clk = ~bist_clk;

    bist_next_sequencer #(.STEP_W(8), .TO_W(16)) dut (
        .bist_clk       (bist_clk),
        .reset          (reset),
        .start          (start),
        .num_steps      (num_steps),
        .timeout_cycles (timeout_cycles),
        .abort          (abort),
        .bist_next      (bist_next),
        .bist_next_ack  (bist_next_ack),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .step_cnt       (step_cnt),
        .err_step       (err_step)
    );

    // downstream model
    logic ack_auto = 1'b1;
    logic ack_man = 1'b0;
    logic d1 = 1'b0;
    logic d2 = 1'b0;
    always @(posedge bist_clk) begin
        d1 <= bist_next;
        d2 <= d1;
    end
    assign bist_next_ack = ack_auto ? d2 : ack_man;

    // monitor
    int   pulses = 0;
    int   dones = 0;
    int   busyc = 0;
    int   cur_run = 0;
    int   last_run = 0;
    logic prev_bn = 1'b0;
    always @(negedge bist_clk) begin
        prev_bn <= bist_next;
        if (bist_next && !prev_bn) pulses <= pulses + 1;
        if (done) dones <= dones + 1;
        if (busy) busyc <= busyc + 1;
        if (bist_next) cur_run <= cur_run + 1;
        else begin
            if (prev_bn) last_run <= cur_run;
            cur_run <= 0;
        end
    end

    typedef struct {
        int pulses;
        int dones;
        int step;
        int err;
        int estep;
    } exp_t;

    exp_t exp_q[$];
    int   p0, d0, b0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_seq(input int p, input int d, input int s,
                              input int e, input int es);
        exp_t x;
        x.pulses = p;
        x.dones  = d;
        x.step   = s;
        x.err    = e;
        x.estep  = es;
        exp_q.push_back(x);
        p0 = pulses;
        d0 = dones;
        b0 = busyc;
    endtask

    task automatic start_seq(input int n, input int t);
        @(posedge bist_clk);
        #1;
        start = 1'b1;
        num_steps = 8'(n);
        timeout_cycles = 16'(t);
        @(posedge bist_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge bist_clk);
            n++;
        end
        chk("idle_wait", int'(busy), 0);
        repeat (2) @(negedge bist_clk);
    endtask

    task automatic check_sb(input string tag);
        exp_t x;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        x = exp_q.pop_front();
        chk({tag, "_pulses"}, pulses - p0, x.pulses);
        chk({tag, "_done"}, dones - d0, x.dones);
        chk({tag, "_step"}, int'(step_cnt), x.step);
        chk({tag, "_err"}, int'(error), x.err);
        chk({tag, "_estep"}, int'(err_step), x.estep);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge bist_clk);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge bist_clk);
        #1 reset = 1'b0;
        @(negedge bist_clk);
        chk("rst_bn", int'(bist_next), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(error), 0);
        chk("rst_step", int'(step_cnt), 0);
        chk("rst_estep", int'(err_step), 0);

        // three steps, no timeout, start while busy ignored
        expect_seq(3, 1, 3, 0, 0);
        start_seq(3, 0);
        @(negedge bist_clk);
        chk("lat_bn", int'(bist_next), 1);
        chk("lat_busy", int'(busy), 1);
        idle(3);
        start_seq(1, 0);
        wait_idle(200);
        check_sb("three");

        // zero steps
        idle(3);
        expect_seq(0, 1, 0, 0, 0);
        start_seq(0, 0);
        @(negedge bist_clk);
        chk("zero_done", int'(done), 1);
        wait_idle(20);
        chk("zero_busy", busyc - b0, 0);
        check_sb("zero");

        // timeout on step 2's request
        idle(3);
        expect_seq(3, 0, 2, 1, 2);
        start_seq(4, 5);
        n = 0;
        while (!(bist_next && step_cnt == 8'd2) && n < 200) begin
            @(negedge bist_clk);
            n++;
        end
        chk("tmo_reach", n < 200 ? 1 : 0, 1);
        ack_man = 1'b0;
        ack_auto = 1'b0;
        wait_idle(50);
        chk("tmo_run", last_run, 5);
        chk("tmo_bn", int'(bist_next), 0);
        idle(4);
        check_sb("tmo");

        // reset in REQ with ack high
        idle(3);
        start_seq(2, 0);
        ack_man = 1'b1;
        reset = 1'b1;
        @(posedge bist_clk);
        #1 reset = 1'b0;
        @(negedge bist_clk);
        chk("mrst_bn", int'(bist_next), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_step", int'(step_cnt), 0);
        p0 = dones;
        start_seq(2, 0);
        idle(3);
        chk("ign_busy", int'(busy), 0);
        chk("ign_done", dones - p0, 0);
        ack_man = 1'b0;
        ack_auto = 1'b1;
        idle(3);
        expect_seq(2, 1, 2, 0, 0);
        start_seq(2, 0);
        wait_idle(200);
        check_sb("after_rst");

        // abort in RELEASE with step_cnt==1
        idle(3);
        expect_seq(2, 0, 1, 0, 0);
        start_seq(3, 0);
        n = 0;
        while (!(busy && !bist_next && step_cnt == 8'd1) && n < 200) begin
            @(negedge bist_clk);
            n++;
        end
        abort = 1'b1;
        @(posedge bist_clk);
        #1 abort = 1'b0;
        @(negedge bist_clk);
        chk("abort_idle", int'(busy), 0);
        wait_idle(20);
        check_sb("abort");
        idle(5);
        expect_seq(2, 1, 2, 0, 0);
        start_seq(2, 0);
        wait_idle(200);
        check_sb("post_abort");

        // abort and timeout on the same edge
        idle(3);
        ack_auto = 1'b0;
        ack_man = 1'b0;
        expect_seq(1, 0, 0, 0, 0);
        start_seq(1, 3);
        @(posedge bist_clk);
        @(posedge bist_clk);
        #1 abort = 1'b1;
        @(posedge bist_clk);
        #1 abort = 1'b0;
        @(negedge bist_clk);
        chk("abt_tmo_busy", int'(busy), 0);
        wait_idle(20);
        check_sb("abt_tmo");
        ack_auto = 1'b1;

        // timeout limit just above the handshake wait
        idle(3);
        expect_seq(2, 1, 2, 0, 0);
        start_seq(2, 4);
        wait_idle(200);
        check_sb("to4");

        // timeout limit equal to the ack wait: timeout wins
        idle(3);
        expect_seq(1, 0, 0, 1, 0);
        start_seq(2, 3);
        wait_idle(200);
        check_sb("to3");

        // reset clears sticky error
        idle(3);
        reset = 1'b1;
        @(posedge bist_clk);
        #1 reset = 1'b0;
        @(negedge bist_clk);
        chk("rst_err_clr", int'(error), 0);

        // maximum step count
        idle(3);
        expect_seq(255, 1, 255, 0, 0);
        start_seq(255, 0);
        wait_idle(3000);
        check_sb("max");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
